// File: rtl/cgol_pkg.sv
// cgol_pkg: board geometry, row/address types and toroidal index helpers.
package cgol_pkg;
    localparam int ROWS   = 8;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int GEN_W  = 16;

    typedef logic [WIDTH-1:0]  row_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // ROWS is a power of two, so row wrap is plain modular arithmetic
    function automatic addr_t row_inc(input addr_t r);
        return addr_t'(r + 1'b1);
    endfunction

    function automatic addr_t row_dec(input addr_t r);
        return addr_t'(r - 1'b1);
    endfunction

    function automatic int col_inc(input int c);
        return (c == WIDTH - 1) ? 0 : c + 1;
    endfunction

    function automatic int col_dec(input int c);
        return (c == 0) ? WIDTH - 1 : c - 1;
    endfunction
endpackage

// File: rtl/cgol_row_rule.sv
// cgol_row_rule: combinational life rule for one row given its toroidal row neighbours.
import cgol_pkg::*;

module cgol_row_rule (
    input  row_t above,
    input  row_t cur,
    input  row_t below,
    output row_t nxt
);
    logic [3:0] n;

    always_comb begin
        nxt = '0;
        n   = '0;
        for (int c = 0; c < WIDTH; c++) begin
            n = 4'(above[col_dec(c)]) + 4'(above[c]) + 4'(above[col_inc(c)])
              + 4'(cur[col_dec(c)])                  + 4'(cur[col_inc(c)])
              + 4'(below[col_dec(c)]) + 4'(below[c]) + 4'(below[col_inc(c)]);
            nxt[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
        end
    end
endmodule

// File: rtl/cgol_board_engine.sv
// cgol_board_engine: life board with shadow buffer, driven by the sweep controller's addr/RWSelect.
import cgol_pkg::*;

module cgol_board_engine (
    input  logic              ph1,
    input  logic              reset,
    input  addr_t             addr,
    input  logic              RWSelect,
    input  logic              load_en,
    input  addr_t             load_addr,
    input  row_t              load_data,
    input  addr_t             rd_addr,
    output row_t              rd_data,
    output logic [GEN_W-1:0]  generation,
    output logic              gen_done
);
    row_t board  [ROWS];
    row_t shadow [ROWS];
    row_t rule_row;
    logic commit;

    cgol_row_rule u_rule (
        .above (board[row_dec(addr)]),
        .cur   (board[addr]),
        .below (board[row_inc(addr)]),
        .nxt   (rule_row)
    );

    assign commit  = !RWSelect && (addr == addr_t'(ROWS - 1)) && !load_en;
    assign rd_data = board[rd_addr];

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                board[r]  <= '0;
                shadow[r] <= '0;
            end
            generation <= '0;
            gen_done   <= 1'b0;
        end else begin
            if (RWSelect)
                shadow[addr] <= rule_row;
            else
                board[addr] <= shadow[addr];
            // later assignment wins, so a load overrides sweep activity on the same row
            if (load_en) begin
                board[load_addr]  <= load_data;
                shadow[load_addr] <= load_data;
            end
            gen_done <= commit;
            if (commit)
                generation <= generation + GEN_W'(1);
        end
    end
endmodule

// File: tb/tb_cgol_board_engine.sv
// tb_cgol_board_engine: directed checks of life rule, sweeps, commit, load priority and reset.
module tb_cgol_board_engine;
    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  addr = '0;
    logic        RWSelect = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [7:0]  load_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [15:0] generation;
    logic        gen_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_base = 0;

    cgol_board_engine dut (
        .ph1        (ph1),
        .reset      (reset),
        .addr       (addr),
        .RWSelect   (RWSelect),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .generation (generation),
        .gen_done   (gen_done)
    );

    always #5 ph1 = ~ph1;

    always @(posedge ph1) if (gen_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        done_base = done_cnt;
    endtask

    task automatic load_row(input logic [2:0] a, input logic [7:0] d);
        RWSelect  = 1'b1;
        addr      = '0;
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic sweep_step(input logic rw, input logic [2:0] a);
        RWSelect = rw;
        addr     = a;
        step();
    endtask

    task automatic run_compute(input int sweeps);
        for (int s = 0; s < sweeps; s++)
            for (int a = 0; a < 8; a++) sweep_step(1'b1, 3'(a));
    endtask

    task automatic run_period();
        run_compute(7);
        for (int a = 0; a < 8; a++) sweep_step(1'b0, 3'(a));
    endtask

    task automatic idle();
        RWSelect = 1'b1;
        addr     = '0;
    endtask

    // exp holds row r in bits [8r+7:8r]
    task automatic check_board(input string tag, input logic [63:0] exp);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), 32'(rd_data), 32'(exp[r*8 +: 8]));
        end
    endtask

    initial begin
        #3;
        check_board("rst_board", 64'h0);
        check("rst_gen", 32'(generation), 32'd0);
        check("rst_done", 32'(gen_done), 32'd0);
        reset = 1'b1;
        done_base = done_cnt;

        load_row(3'd3, 8'h1C);
        run_period();
        check("blk1_pulse", 32'(gen_done), 32'd1);
        idle();
        check_board("blk1", 64'h0000_0008_0808_0000);
        check("blk1_gen", 32'(generation), 32'd1);
        step();
        check("blk1_pulse_end", 32'(gen_done), 32'd0);
        check("blk1_cnt", 32'(done_cnt - done_base), 32'd1);
        run_period();
        check_board("blk2", 64'h0000_0000_1C00_0000);
        check("blk2_gen", 32'(generation), 32'd2);
        check("blk2_pulse", 32'(gen_done), 32'd1);

        reset = 1'b0;
        #1;
        check_board("midrst", 64'h0);
        check("midrst_gen", 32'(generation), 32'd0);
        check("midrst_done", 32'(gen_done), 32'd0);
        idle();
        reset = 1'b1;
        done_base = done_cnt;

        do_reset();
        load_row(3'd0, 8'h81);
        load_row(3'd7, 8'h81);
        for (int p = 0; p < 3; p++) run_period();
        idle();
        check_board("still", 64'h8100_0000_0000_0081);
        check("still_gen", 32'(generation), 32'd3);
        step();
        check("still_cnt", 32'(done_cnt - done_base), 32'd3);

        do_reset();
        load_row(3'd3, 8'h1C);
        run_compute(7);
        check_board("iso_cmp", 64'h0000_0000_1C00_0000);
        check("iso_gen0", 32'(generation), 32'd0);
        for (int a = 0; a < 3; a++) sweep_step(1'b0, 3'(a));
        rd_addr = 3'd2;
        #1;
        check("iso_wb_r2", 32'(rd_data), 32'h08);
        rd_addr = 3'd3;
        #1;
        check("iso_wb_r3", 32'(rd_data), 32'h1C);
        check("iso_wb_gen", 32'(generation), 32'd0);
        for (int a = 3; a < 8; a++) sweep_step(1'b0, 3'(a));
        idle();
        check_board("iso_done", 64'h0000_0008_0808_0000);
        check("iso_gen1", 32'(generation), 32'd1);

        do_reset();
        run_compute(7);
        for (int a = 0; a < 8; a++) begin
            load_en   = (a == 5) || (a == 7);
            load_addr = (a == 5) ? 3'd5 : 3'd2;
            load_data = (a == 5) ? 8'hA5 : 8'h3C;
            sweep_step(1'b0, 3'(a));
        end
        load_en = 1'b0;
        check("coll_pulse", 32'(gen_done), 32'd0);
        idle();
        check_board("coll", 64'h0000_A500_003C_0000);
        check("coll_gen", 32'(generation), 32'd0);
        step();
        check("coll_cnt", 32'(done_cnt - done_base), 32'd0);

        do_reset();
        load_row(3'd4, 8'h10);
        run_period();
        idle();
        check_board("lone", 64'h0);
        check("lone_gen", 32'(generation), 32'd1);
        run_period();
        idle();
        check_board("empty", 64'h0);
        check("empty_gen", 32'(generation), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cgol_board_engine.md
Name: cgol_board_engine

Overview:
- Downstream consumer of the sweep controller's `addr` / `RWSelect` outputs.
- Holds the Game-of-Life board as ROWS x WIDTH cell registers, plus a shadow next-generation buffer.
- Compute sweeps: evaluates the life rule row by row into the shadow buffer.
- Write-back sweep: commits the shadow buffer to the board.
- Also provides an external load port, a readback port and a generation counter.

Parameters:
- ROWS, 8, board rows; must be 2**ADDR_W.
- WIDTH, 8, cells per row.
- ADDR_W, 3, row address width; matches controller addr.
- GEN_W, 16, generation counter width.

Ports:
- ph1  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  row address from controller, valid every cycle.
- RWSelect  input  1  1 = compute sweep, 0 = write-back sweep.
- load_en  input  1  write load_data into board and shadow row load_addr.
- load_addr  input  ADDR_W  load row.
- load_data  input  WIDTH  load row value; bit i = cell column i.
- rd_addr  input  ADDR_W  readback row.
- rd_data  output  WIDTH  board[rd_addr]; combinational readback of the committed board.
- generation  output  GEN_W  number of committed generations.
- gen_done  output  1  one-cycle pulse per committed generation.

Behaviour:
- Reset (async assert, sync release), all outputs and state:
  - board = 0, shadow = 0
  - generation = 0, gen_done = 0
  - rd_data therefore reads 0.
- Board topology:
  - Toroidal in both axes.
  - Row neighbours of r are (r-1) mod ROWS and (r+1) mod ROWS.
  - Column neighbours of c are (c-1) mod WIDTH and (c+1) mod WIDTH.
- Life rule per cell:
  - n = live count of the 8 neighbours, 4-bit unsigned, range 0..8.
  - next = (n==3) | (alive & n==2).
- Compute (RWSelect=1):
  - At each rising edge, shadow[addr] <= rule(board[addr-1], board[addr], board[addr+1]).
  - Board is unchanged, so repeated compute sweeps are idempotent.
  - Latency: result is in shadow one edge after addr is presented.
- Write-back (RWSelect=0):
  - At each rising edge, board[addr] <= shadow[addr]; shadow is unchanged.
  - rd_data reflects the new row the cycle after that edge.
- Generation commit:
  - Condition: an edge with RWSelect=0, addr==ROWS-1 and load_en=0.
  - At that edge: generation <= generation+1, wrapping modulo 2**GEN_W.
  - gen_done is registered: high for exactly the following cycle.
- Load priority:
  - When load_en=1, board[load_addr] and shadow[load_addr] <= load_data.
  - Load overrides any compute or write-back to the same row in that cycle.
  - A compute or write-back to a different row in the same cycle still occurs.
  - A load coinciding with the commit edge suppresses that generation increment and the gen_done pulse.
- RWSelect is sampled every edge with no handshake. The block relies on the controller contract:
  - 7 compute sweeps followed by 1 write-back sweep.
  - addr increments by 1 each cycle and wraps ROWS-1 -> 0.
  - A partial write-back sweep (e.g. after a controller reset) commits only the rows visited. This is defined, not an error.
- Reset asserted mid-sweep clears all state immediately, independent of ph1.

Decomposition:
- Package cgol_pkg holds:
  - ROWS, WIDTH, ADDR_W, GEN_W constants
  - row_t typedef (logic [WIDTH-1:0])
  - addr_t typedef
  - wrap-increment/decrement helper functions for row and column indices.
- Sub-module cgol_row_rule: purely combinational; inputs above/cur/below row_t, output next row_t. It is instantiated once and fed by the addr-indexed row muxes.
- Top level holds the board/shadow arrays, load priority, commit and generation logic.

Test Plan:
- Reset: drive reset=0 mid-run with board populated -> rd_data=0 for all rd_addr, generation=0, gen_done=0 within the same cycle.
- Blinker: load row3=8'b00011100, run one controller period of 64 cycles -> rows 2,3,4 = 8'b00001000, all others 0, generation=1, single gen_done pulse. Second period -> row3=8'b00011100 again, generation=2.
- Toroidal still life: load row0=8'b10000001 and row7=8'b10000001 (2x2 block across both wraps), run 3 periods -> board unchanged, generation=3.
- Commit isolation: load blinker, run 7 compute sweeps (56 cycles) -> rd_data for rows 2,3,4 still 0, 0x1C, 0 and generation=0. The change appears only during the write-back sweep.
- Load collision: during write-back at addr=5, load_en=1 with load_addr=5 and load_data=8'hA5 -> board[5]=8'hA5 afterwards. Loading at addr=7 on the commit edge -> generation not incremented, no gen_done.
- Single cell dies and empty board stays empty: load row4=8'h10, run 1 period -> all rows 0, generation=1.
